add_tree_acc: RTL and testbench

ADD_TREE_ACC -- requirements
Module: add_tree_acc

---
 rtl/bnn_pkg.sv | 40 ++++
 rtl/tree_level.sv | 34 +++
 rtl/add_tree_acc.sv | 186 ++++++++++++++++++
 tb/tb_add_tree_acc.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// =============================================================================
// Module : bnn_pkg
// Brief  : Shared width helpers and accumulator state type for add_tree_acc.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package bnn_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    function automatic int w_el(input int width_in);
        return width_in + 11;
    endfunction

    // Number of 4:1 reduction levels needed to collapse n_in lanes to one.
    function automatic int tree_levels(input int n_in);
        int lv;
        int n;
        lv = 0;
        n  = n_in;
        for (int i = 0; i < 16; i++) begin
            if (n > 1) begin
                n  = n / 4;
                lv = lv + 1;
            end
        end
        return lv;
    endfunction

    function automatic int w_out(input int width_in, input int n_in, input int max_beats);
        return w_el(width_in) + 2 * tree_levels(n_in) + $clog2(max_beats);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tree_level.sv
// =============================================================================
// Module : tree_level
// Brief  : One registered 4:1 adder level; each group of four lanes becomes one
//          lane two bits wider so the sum can never wrap.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tree_level #(
    parameter int N_LANES = 4,
    parameter int W_IN    = 19
) (
    input  logic                              clk,
    input  logic [N_LANES-1:0][W_IN-1:0]      i_data,
    output logic [N_LANES/4-1:0][W_IN+1:0]    o_sum
);

    localparam int c_n_out = N_LANES / 4;

    function automatic logic [W_IN+1:0] sext2(input logic [W_IN-1:0] x);
        return {{2{x[W_IN-1]}}, x};
    endfunction

    // Data registers carry no reset: downstream only trusts them alongside valid.
    always_ff @(posedge clk) begin
        for (int g = 0; g < c_n_out; g++) begin
            o_sum[g] <= sext2(i_data[4*g])   + sext2(i_data[4*g+1])
                      + sext2(i_data[4*g+2]) + sext2(i_data[4*g+3]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/add_tree_acc.sv
// =============================================================================
// Module : add_tree_acc
// Brief  : Pipelined 4-ary adder tree feeding a multi-beat signed accumulator.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module add_tree_acc
    import bnn_pkg::*;
#(
    parameter int N_IN      = 256,
    parameter int WIDTH_IN  = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             in_valid,
    input  logic                                             in_last,
    input  logic signed [N_IN-1:0][w_el(WIDTH_IN)-1:0]       in,
    output logic                                             out_valid,
    output logic signed [w_out(WIDTH_IN,N_IN,MAX_BEATS)-1:0] out,
    output logic                                             out_ovf
);

    localparam int c_w_el   = w_el(WIDTH_IN);
    localparam int c_levels = tree_levels(N_IN);
    localparam int c_w_tree = c_w_el + 2 * c_levels;
    localparam int c_w_out  = w_out(WIDTH_IN, N_IN, MAX_BEATS);
    localparam int c_w_ext  = c_w_out - c_w_tree;
    localparam int c_w_cnt  = $clog2(MAX_BEATS + 2);

    localparam logic [c_w_cnt-1:0] c_cnt_one = c_w_cnt'(1);
    localparam logic [c_w_cnt-1:0] c_cnt_max = c_w_cnt'(MAX_BEATS);
    localparam logic [c_w_cnt-1:0] c_cnt_sat = c_w_cnt'(MAX_BEATS + 1);

    // ------------------------------------------------------------------ tree
    genvar lv;
    generate
        for (lv = 0; lv < c_levels; lv++) begin : g_level
            localparam int c_n = N_IN >> (2 * lv);
            localparam int c_w = c_w_el + 2 * lv;

            logic [c_n-1:0][c_w-1:0]   w_din;
            logic [c_n/4-1:0][c_w+1:0] w_lvl_sum;

            if (lv == 0) begin : g_first
                assign w_din = in;
            end else begin : g_inner
                assign w_din = g_level[lv-1].w_lvl_sum;
            end

            tree_level #(
                .N_LANES (c_n),
                .W_IN    (c_w)
            ) u_level (
                .clk     (clk),
                .i_data  (w_din),
                .o_sum   (w_lvl_sum)
            );
        end
    endgenerate

    logic [c_w_tree-1:0] w_tree_sum;
    logic [c_w_out-1:0]  w_beat_sum;

    assign w_tree_sum = g_level[c_levels-1].w_lvl_sum[0];

    generate
        if (c_w_ext > 0) begin : g_ext
            assign w_beat_sum = {{c_w_ext{w_tree_sum[c_w_tree-1]}}, w_tree_sum};
        end else begin : g_noext
            assign w_beat_sum = w_tree_sum;
        end
    endgenerate

    // ------------------------------------------------- valid/last alignment
    logic [c_levels-1:0] r_vld_pipe;
    logic [c_levels-1:0] r_lst_pipe;
    logic                w_beat;
    logic                w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_lst_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= in_valid;
            r_lst_pipe[0] <= in_valid & in_last;
            for (int i = 1; i < c_levels; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_lst_pipe[i] <= r_lst_pipe[i-1];
            end
        end
    end

    assign w_beat = r_vld_pipe[c_levels-1];
    assign w_last = r_lst_pipe[c_levels-1];

    // ----------------------------------------------------------- accumulator
    acc_state_e          r_state;
    acc_state_e          w_state_nxt;
    logic [c_w_out-1:0]  r_acc;
    logic [c_w_out-1:0]  w_acc_nxt;
    logic [c_w_out-1:0]  w_acc_sum;
    logic [c_w_cnt-1:0]  r_cnt;
    logic [c_w_cnt-1:0]  w_cnt_nxt;
    logic [c_w_out-1:0]  r_out;
    logic [c_w_out-1:0]  w_out_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_ovf;
    logic                w_ovf_nxt;

    assign w_acc_sum = r_acc + w_beat_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_ovf_nxt   = r_ovf;
        w_valid_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_beat) begin
                    if (w_last) begin
                        w_out_nxt   = w_beat_sum;
                        w_ovf_nxt   = 1'b0;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_acc_nxt   = w_beat_sum;
                        w_cnt_nxt   = c_cnt_one;
                        w_state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (w_beat) begin
                    if (w_last) begin
                        // Counting the closing beat, the result overflows once
                        // the beats already held reach MAX_BEATS.
                        w_out_nxt   = w_acc_sum;
                        w_ovf_nxt   = (r_cnt >= c_cnt_max);
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_acc_nxt = w_acc_sum;
                        if (r_cnt != c_cnt_sat) begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign out_valid = r_valid;
    assign out       = r_out;
    assign out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_add_tree_acc.sv
// =============================================================================
// Module : tb_add_tree_acc
// Brief  : Directed self-checking bench for add_tree_acc (16 lanes, 4 beats).
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_add_tree_acc;

    localparam int N_IN      = 16;
    localparam int WIDTH_IN  = 8;
    localparam int MAX_BEATS = 4;
    localparam int W_EL      = 19;
    localparam int W_OUT     = 25;
    localparam int LAT       = 3;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic                           in_valid = 1'b0;
    logic                           in_last = 1'b0;
    logic signed [N_IN-1:0][W_EL-1:0] in_d = '0;
    logic                           out_valid;
    logic signed [W_OUT-1:0]        out_d;
    logic                           out_ovf;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_ref = 0;

    logic signed [W_OUT-1:0] q_out[$];
    logic                    q_ovf[$];
    int                      q_cyc[$];

    add_tree_acc #(
        .N_IN      (N_IN),
        .WIDTH_IN  (WIDTH_IN),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in        (in_d),
        .out_valid (out_valid),
        .out       (out_d),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            q_out.push_back(out_d);
            q_ovf.push_back(out_ovf);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int v);
        for (int i = 0; i < N_IN; i++) in_d[i] = W_EL'(v);
    endtask

    task automatic beat(input int v, input bit last);
        set_lanes(v);
        in_valid = 1'b1;
        in_last  = last;
        t_ref    = cyc;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_q();
        q_out.delete();
        q_ovf.delete();
        q_cyc.delete();
    endtask

    task automatic expect_result(input string tag, input int exp_out,
                                 input bit exp_ovf, input int exp_cyc);
        if (q_out.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            check({tag, "_out"}, q_out.pop_front(), exp_out);
            check({tag, "_ovf"}, q_ovf.pop_front(), exp_ovf);
            check({tag, "_cycle"}, q_cyc.pop_front(), exp_cyc);
        end
    endtask

    initial begin
        int t0;

        // Reset state
        rst = 1'b1;
        idle(3);
        check("rst_valid", out_valid, 0);
        check("rst_out", out_d, 0);
        check("rst_ovf", out_ovf, 0);
        clear_q();

        // Single beat, all ones, driven in the first cycle after reset
        rst = 1'b0;
        beat(1, 1'b1);
        t0 = t_ref;
        idle(6);
        check("ones_count", q_out.size(), 1);
        expect_result("ones", 16, 1'b0, t0 + LAT);
        check("ones_hold_out", out_d, 16);
        check("ones_hold_valid", out_valid, 0);
        clear_q();

        // Most-negative element in every lane
        beat(-262144, 1'b1);
        t0 = t_ref;
        idle(6);
        check("neg_count", q_out.size(), 1);
        expect_result("neg", -4194304, 1'b0, t0 + LAT);
        clear_q();

        // Most-positive element in every lane
        beat(262143, 1'b1);
        t0 = t_ref;
        idle(6);
        expect_result("pos", 4194288, 1'b0, t0 + LAT);
        clear_q();

        // Mixed-sign lanes: lane i = i-8, sum = -8
        for (int i = 0; i < N_IN; i++) in_d[i] = W_EL'(i - 8);
        in_valid = 1'b1;
        in_last  = 1'b1;
        t0 = cyc;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        idle(6);
        expect_result("mixed", -8, 1'b0, t0 + LAT);
        clear_q();

        // Three beats with gaps (cycles 0, 2, 7)
        beat(2, 1'b0);
        idle(1);
        beat(2, 1'b0);
        idle(4);
        beat(2, 1'b1);
        t0 = t_ref;
        idle(6);
        check("gap_count", q_out.size(), 1);
        expect_result("gap", 96, 1'b0, t0 + LAT);
        clear_q();

        // Back-to-back single-beat results, lanes = k
        t0 = cyc;
        for (int k = 0; k < 8; k++) begin
            set_lanes(k);
            in_valid = 1'b1;
            in_last  = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        idle(6);
        check("b2b_count", q_out.size(), 8);
        for (int k = 0; k < 8; k++) begin
            expect_result($sformatf("b2b%0d", k), 16 * k, 1'b0, t0 + LAT + k);
        end
        clear_q();

        // Five beats with MAX_BEATS=4 overflow, then a clean single beat
        for (int k = 0; k < 5; k++) beat(1, k == 4);
        t0 = t_ref;
        beat(1, 1'b1);
        idle(6);
        check("ovf_count", q_out.size(), 2);
        expect_result("ovf5", 80, 1'b1, t0 + LAT);
        expect_result("ovf_next", 16, 1'b0, t0 + 1 + LAT);
        clear_q();

        // Exactly MAX_BEATS beats is not an overflow
        for (int k = 0; k < 4; k++) beat(1, k == 3);
        t0 = t_ref;
        idle(6);
        expect_result("four", 64, 1'b0, t0 + LAT);
        clear_q();

        // Reset during beat 2 of 3 discards the partial result
        beat(5, 1'b0);
        set_lanes(5);
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrst_out", out_d, 0);
        check("midrst_valid", out_valid, 0);
        beat(3, 1'b1);
        t0 = t_ref;
        idle(6);
        check("midrst_count", q_out.size(), 1);
        expect_result("midrst", 48, 1'b0, t0 + LAT);
        clear_q();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
